// File: rtl/lsu.sv
// Memory-stage load/store unit: one outstanding req/gnt/rvalid transaction,
// lane steering for stores, aligned extraction and extension for loads.
module lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic                  op_load_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  wb_valid_o,
  output logic [31:0]           wb_data_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic        load_p0;
  logic        fault_p0;
  logic [2:0]  funct3_p0;
  logic [1:0]  off_p0;
  logic [31:0] rdata_p1;

  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   be_gen = 4'b0001 << o;
      2'b01:   be_gen = 4'b0011 << o;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   wdata_gen = {4{w[7:0]}};
      2'b01:   wdata_gen = {2{w[15:0]}};
      default: wdata_gen = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> {o, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
      3'b100:  load_ext = {24'h0, s[7:0]};
      3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
      3'b101:  load_ext = {16'h0, s[15:0]};
      default: load_ext = s;
    endcase
  endfunction

  // Illegal encodings and misaligned halfword/word accesses never reach the bus.
  function automatic logic is_fault(input logic ld, input logic [2:0] f3, input logic [1:0] o);
    logic illegal;
    logic mis;
    illegal  = ld ? (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                  : (f3[2] || f3[1:0] == 2'b11);
    mis      = (f3[1:0] == 2'b01 && o[0]) || (f3[1:0] == 2'b10 && o != 2'b00);
    is_fault = illegal || mis;
  endfunction

  assign ex_ready_o = (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'h0;
      data_addr_o  <= '0;
      data_wdata_o <= 32'h0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= 32'h0;
      misaligned_o <= 1'b0;
    end else begin
      wb_valid_o   <= 1'b0;
      wb_data_o    <= 32'h0;
      misaligned_o <= 1'b0;
      case (state)
        // p0: accept op from execute and present the bus request
        IDLE: if (ex_valid_i) begin
          load_p0   <= op_load_i;
          funct3_p0 <= funct3_i;
          off_p0    <= addr_i[1:0];
          fault_p0  <= is_fault(op_load_i, funct3_i, addr_i[1:0]);
          if (is_fault(op_load_i, funct3_i, addr_i[1:0])) begin
            state <= RESP;
          end else begin
            state        <= REQ;
            data_req_o   <= 1'b1;
            data_we_o    <= !op_load_i;
            data_be_o    <= be_gen(funct3_i, addr_i[1:0]);
            data_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            data_wdata_o <= wdata_gen(funct3_i, wdata_i);
          end
        end
        REQ: if (data_gnt_i) begin
          data_req_o <= 1'b0;
          state      <= load_p0 ? WAIT : RESP;
        end
        // p1: capture extracted read data
        WAIT: if (data_rvalid_i) begin
          rdata_p1 <= load_ext(funct3_p0, off_p0, data_rdata_i);
          state    <= RESP;
        end
        // p2: single-cycle writeback pulse
        RESP: begin
          wb_valid_o   <= 1'b1;
          misaligned_o <= fault_p0;
          wb_data_o    <= (load_p0 && !fault_p0) ? rdata_p1 : 32'h0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed ops with a bus responder and a
// scoreboard of expected writeback results.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ex_valid;
  logic        ex_ready;
  logic        op_load;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        misaligned;

  int n_chk = 0;
  int n_err = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  lsu #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .op_load_i(op_load), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_we_o(data_we),
    .data_be_o(data_be), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .wb_valid_o(wb_valid), .wb_data_o(wb_data), .misaligned_o(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_data", wb_data, e[31:0]);
        chk("misaligned", {31'h0, misaligned}, {31'h0, e[32]});
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'h0, data_req}, 32'd0);
    chk({tag, "_we"}, {31'h0, data_we}, 32'd0);
    chk({tag, "_be"}, {28'h0, data_be}, 32'd0);
    chk({tag, "_addr"}, data_addr, 32'd0);
    chk({tag, "_wdata"}, data_wdata, 32'd0);
    chk({tag, "_wbv"}, {31'h0, wb_valid}, 32'd0);
    chk({tag, "_wbd"}, wb_data, 32'd0);
    chk({tag, "_mis"}, {31'h0, misaligned}, 32'd0);
    chk({tag, "_ready"}, {31'h0, ex_ready}, 32'd1);
  endtask

  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int dly,
                       input logic flt, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] eres, input logic hold);
    int c;
    int lat;
    lat = flt ? 1 : (ld ? 3 + dly : 2 + dly);
    sb.push_back({flt, (flt || !ld) ? 32'h0 : eres});
    ex_valid = 1'b1; op_load = ld; funct3 = f3; addr = a; wdata = wd;
    chk("ready_before", {31'h0, ex_ready}, 32'd1);
    @(negedge clk);
    c = 0;
    if (!hold) ex_valid = 1'b0;
    chk("busy", {31'h0, ex_ready}, 32'd0);
    if (!flt) begin
      for (int k = 0; k <= dly; k++) begin
        chk("req", {31'h0, data_req}, 32'd1);
        chk("addr", data_addr, {a[31:2], 2'b00});
        chk("be", {28'h0, data_be}, {28'h0, ebe});
        chk("we", {31'h0, data_we}, {31'h0, !ld});
        if (!ld) chk("wdata", data_wdata, ewd);
        if (k == dly) data_gnt = 1'b1;
        @(negedge clk);
        c++;
      end
      data_gnt = 1'b0;
      chk("req_drop", {31'h0, data_req}, 32'd0);
      if (ld) begin
        data_rvalid = 1'b1;
        data_rdata = rd;
        @(negedge clk);
        c++;
        data_rvalid = 1'b0;
        data_rdata = $urandom;
      end
    end
    while (wb_valid !== 1'b1 && c < 30) begin
      if (flt) chk("fault_noreq", {31'h0, data_req}, 32'd0);
      @(negedge clk);
      c++;
    end
    if (hold) ex_valid = 1'b0;
    chk("wb_seen", {31'h0, wb_valid}, 32'd1);
    chk("latency", c, lat);
    @(negedge clk);
    chk("wb_pulse", {31'h0, wb_valid}, 32'd0);
    chk("wb_data_zero", wb_data, 32'd0);
    chk("mis_zero", {31'h0, misaligned}, 32'd0);
    chk("no_reaccept", {31'h0, data_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; ex_valid = 1'b0; op_load = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    // ld, f3, addr, wdata, rdata, gnt delay, fault, be, store lanes, load result, hold
    do_op(1'b0, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_op(1'b0, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
    do_op(1'b1, 3'b000, 32'h2000_0002, 32'h0, 32'h1280_3456, 3, 1'b0, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_op(1'b1, 3'b100, 32'h2000_0002, 32'h0, 32'h1280_3456, 3, 1'b0, 4'b0100, 32'h0, 32'h0000_0080, 1'b0);
    do_op(1'b1, 3'b001, 32'h2000_0001, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    do_op(1'b1, 3'b010, 32'h2000_0002, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    do_op(1'b1, 3'b101, 32'h3000_0002, 32'h0, 32'h8001_0000, 1, 1'b0, 4'b1100, 32'h0, 32'h0000_8001, 1'b1);
    do_op(1'b0, 3'b001, 32'h3000_0006, 32'h1234_ABCD, 32'h0, 2, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
    do_op(1'b1, 3'b010, 32'h4000_0008, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
    do_op(1'b1, 3'b001, 32'h5000_0002, 32'h0, 32'h8765_4321, 0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8765, 1'b0);
    do_op(1'b1, 3'b000, 32'h5000_0003, 32'h0, 32'h7F00_0000, 1, 1'b0, 4'b1000, 32'h0, 32'h0000_007F, 1'b0);
    do_op(1'b0, 3'b100, 32'h0000_0000, 32'h1, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    do_op(1'b1, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);

    // Reset while waiting for read data; the late rvalid must be dropped.
    ex_valid = 1'b1; op_load = 1'b1; funct3 = 3'b010; addr = 32'h6000_0000;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rst_req", {31'h0, data_req}, 32'd1);
    data_gnt = 1'b1;
    @(negedge clk);
    data_gnt = 1'b0;
    chk("rst_wait_req", {31'h0, data_req}, 32'd0);
    chk("rst_wait_busy", {31'h0, ex_ready}, 32'd0);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    check_idle_outputs("midrst");
    data_rvalid = 1'b1;
    data_rdata = 32'h1111_1111;
    @(negedge clk);
    data_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle_outputs("post_rvalid");
      @(negedge clk);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus the store operand and funct3.
- Drives a single-outstanding req/gnt/rvalid data-memory bus with word-aligned address and byte enables.
- Returns an aligned, sign/zero-extended load result (or store completion) to writeback, and flags misaligned or illegal accesses without touching the bus.

Parameters:
- ADDR_WIDTH, 32, width of effective and bus addresses.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- ex_valid_i  in  1  execute stage presents a memory op
- ex_ready_o  out  1  LSU can accept an op this cycle
- op_load_i  in  1  1 = load, 0 = store
- funct3_i  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  ADDR_WIDTH  effective address (ALU result)
- wdata_i  in  32  store data (rs2)
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_we_o  out  1  1 = write
- data_be_o  out  4  byte enables
- data_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[W-1:2],2'b00})
- data_wdata_o  out  32  lane-replicated store data
- data_rvalid_i  in  1  read data valid
- data_rdata_i  in  32  read data
- wb_valid_o  out  1  one-cycle completion pulse
- wb_data_o  out  32  load result; 0 for stores and faults
- misaligned_o  out  1  qualifies wb_valid_o: access faulted, no bus transaction

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - On a clock edge with rst_ni=0: state=IDLE and all registered outputs are 0 (data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, wb_valid_o, wb_data_o, misaligned_o).
- FSM states: IDLE, REQ, WAIT, RESP.
- ex_ready_o = (state==IDLE), combinational from state.
- IDLE: when ex_valid_i && ex_ready_o, latch op, funct3, addr[1:0], aligned address and wdata.
  - Fault if: H/HU with addr[0]=1; W with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - Fault -> RESP with misaligned_o set; the bus is never requested.
  - Otherwise -> REQ.
- REQ: data_req_o=1.
  - data_addr_o, data_we_o, data_be_o and data_wdata_o are held stable until data_gnt_i.
  - On gnt: store -> RESP; load -> WAIT.
  - data_rvalid_i in REQ is ignored (rvalid is never earlier than the cycle after gnt).
- WAIT: data_req_o=0. On data_rvalid_i, register the extracted load data -> RESP. No timeout; stays in WAIT indefinitely.
- RESP: wb_valid_o=1 for exactly one cycle, then IDLE. wb_data_o and misaligned_o are valid only while wb_valid_o=1 and are 0 otherwise.
- Byte enables by offset o = addr[1:0]:
  - SB: be = 4'b0001<<o, wdata = {4{wdata_i[7:0]}}.
  - SH: be = 4'b0011<<o, wdata = {2{wdata_i[15:0]}}.
  - SW: be = 4'b1111, wdata = wdata_i.
- Load extract: s = data_rdata_i >> (8*o).
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: s.
- Latency, accept edge = cycle 0:
  - Store with immediate gnt: wb_valid_o in cycle 2.
  - Load with immediate gnt and rvalid one cycle later: wb_valid_o in cycle 3.
  - Faults: wb_valid_o in cycle 1.
- Only one op in flight; ex_valid_i is ignored while not in IDLE.
- Reset mid-transaction: the op is abandoned and data_req_o drops. A later rvalid for the abandoned request arrives in IDLE and is ignored.
- Back-to-back: a new op can be accepted in the cycle after RESP.

Test Plan:
- SW addr=0x1000_0004, wdata=0xDEADBEEF, gnt same cycle as req -> data_addr_o=0x1000_0004, be=1111, we=1; wb_valid_o cycle 2, wb_data_o=0.
- SB addr=0x0000_0013, wdata=0x0000_00A5 -> be=1000, data_wdata_o=0xA5A5A5A5, data_addr_o=0x0000_0010.
- LB addr=0x…02, rdata=0x1280_3456, gnt delayed 3 cycles -> req held with stable outputs; wb_data_o=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LH addr=0x…01 and LW addr=0x…02 -> no data_req_o ever; wb_valid_o+misaligned_o in cycle 1; wb_data_o=0.
- LHU addr=0x…02, rdata=0x8001_0000 -> 0x0000_8001; ex_valid_i held high during the op -> no second accept until IDLE.
- rst_ni=0 during WAIT, then rvalid arrives -> FSM IDLE, no wb_valid_o, all outputs 0.
